// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_rx_state_t;

    // Widest entry form; the receiver declares its own DATA_BITS-wide copy.
    typedef struct packed {
        logic                          parity_err;
        logic                          frame_err;
        logic [UART_MAX_DATA_BITS-1:0] data;
    } uart_rx_entry_t;

    function automatic int clocks_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Shift-register receive FIFO: mem_q[0] is the head register that drives the outputs,
// a pop shifts every entry down by one.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int IW   = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_err
        $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNTW-1:0]  count_q, count_d;
    logic [IW-1:0]    wr_idx;
    logic             do_pop, do_push;

    assign full_o  = (count_q == CNTW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_push = push_i & (~full_o | do_pop);
    assign wr_idx  = do_pop ? IW'(count_q - 1'b1) : IW'(count_q);
    assign rdata_o = mem_q[0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        count_d = count_q;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
        end
        if (do_push) mem_d[wr_idx] = wdata_i;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority per bit, framing/parity
// checks and a receive FIFO with valid/ready output. Define UART_RX_PARITY_EN for a parity bit.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 10_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overflow,
    output logic                 busy
);
    localparam int CPB  = clocks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    if (CPB < 4) begin : g_cpb_err
        $error("uart_rx_param: CLOCK_RATE/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_err
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
        $error("uart_rx_param: STOP_BITS must be 1..2 and PARITY_ODD 0..1");
    end

    typedef struct packed {
        logic                 parity_err;
        logic                 frame_err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    uart_rx_state_t       state_q, state_d;
    logic                 sync1_q, sync2_q, rxs;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d, perr_q, perr_d;
    logic                 push_q, push_d, overflow_q;
    entry_t               entry_q, entry_d, head;
    logic                 maj, decide, wrap, ferr_new;
    logic                 fifo_full, fifo_empty;

    assign rxs      = sync2_q;
    assign maj      = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    assign decide   = (cnt_q == CNT_DEC);
    assign wrap     = (cnt_q == CNT_LAST);
    assign ferr_new = ferr_q | ~maj;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        push_d  = 1'b0;
        entry_d = entry_q;
        if (cnt_q == CNT_S0) s0_d = rxs;
        if (cnt_q == CNT_S1) s1_d = rxs;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                ferr_d = 1'b0;
                perr_d = 1'b0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (wrap) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
                if (decide && maj) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (wrap) begin
                    cnt_d = '0;
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (decide) perr_d = maj ^ (^shift_q) ^ (PARITY_ODD != 0);
                if (wrap) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // The entry is taken mid-stop-bit so a following start bit is seen in IDLE.
                if (decide) begin
                    ferr_d = ferr_new;
                    if (bit_q == LAST_STOP) begin
                        push_d             = 1'b1;
                        entry_d.parity_err = perr_q;
                        entry_d.frame_err  = ferr_new;
                        entry_d.data       = shift_q;
                        state_d            = ferr_new ? ST_BREAK : ST_IDLE;
                    end
                end
                if (wrap && bit_q != LAST_STOP) begin
                    cnt_d = '0;
                    bit_d = bit_q + 1'b1;
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            shift_q    <= '0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            push_q     <= 1'b0;
            entry_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            shift_q    <= shift_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            push_q     <= push_d;
            entry_q    <= entry_d;
            overflow_q <= push_q & fifo_full & ~ready;
        end
    end

    uart_rx_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .wdata_i (entry_q),
        .pop_i   (ready),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign data       = head.data;
    assign frame_err  = head.frame_err;
    assign parity_err = head.parity_err;
    assign valid      = ~fifo_empty;
    assign overflow   = overflow_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (8 data bits, 1 stop bit, CPB = 86); received entries are
// checked against an expected queue as they leave the FIFO.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int CPB = 86;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          ready = 1'b0;
    logic [DW-1:0] data;
    logic          valid, frame_err, parity_err, overflow, busy;

    int tests_run = 0;
    int failures  = 0;
    int cyc = 0;
    int ovf_cnt = 0;
    int first_valid_cyc = -1;
    logic [DW+1:0] exp_q[$];

    uart_rx_param #(
        .CLOCK_RATE (10_000_000),
        .BAUD_RATE  (115_200),
        .DATA_BITS  (DW),
        .STOP_BITS  (1),
        .PARITY_ODD (0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        tests_run++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Scoreboard: every accepted entry must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (overflow) ovf_cnt++;
            if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (valid && ready) begin
                tests_run++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_entry observed=%0h expected=none",
                           {parity_err, frame_err, data});
                end
                if (exp_q.size() != 0) check("rx_entry", {parity_err, frame_err, data}, exp_q.pop_front());
            end
        end
    end

    task automatic hold_bits(input logic lvl, input int nbits);
        rxd = lvl;
        repeat (nbits * CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] d);
        hold_bits(1'b0, 1);
        for (int i = 0; i < DW; i++) hold_bits(d[i], 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
        send_body(d);
`ifdef UART_RX_PARITY_EN
        hold_bits(^d, 1);
`endif
        hold_bits(stop_lvl, 1);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_with_parity(input logic [7:0] d, input logic par);
        send_body(d);
        hold_bits(par, 1);
        hold_bits(1'b1, 1);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_start;
        int bcnt;
        logic [7:0] ab;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready = 1'b1;
        hold_bits(1'b1, 2);

        // Four back-to-back frames.
        t_start = cyc;
        exp_q.push_back({2'b00, 8'h11}); send_frame(8'h11, 1'b1);
        exp_q.push_back({2'b00, 8'h22}); send_frame(8'h22, 1'b1);
        exp_q.push_back({2'b00, 8'h33}); send_frame(8'h33, 1'b1);
        exp_q.push_back({2'b00, 8'h44}); send_frame(8'h44, 1'b1);
        hold_bits(1'b1, 2);
        check_range("first_latency", first_valid_cyc - t_start, 9 * CPB + CPB / 2, 9 * CPB + CPB / 2 + 10);
        check("b2b_drained", exp_q.size(), 0);

        // 40-cycle glitch on the idle line.
        bcnt = 0;
        rxd = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (i == 39) rxd = 1'b1;
        end
        check_range("glitch_busy_cycles", bcnt, 40, 50);
        @(negedge clk);
        check("glitch_no_valid", valid, 0);
        check("glitch_idle", busy, 0);
        @(posedge clk); #1;

        // Stop bit low, line held low: one errored entry, then BREAK.
        exp_q.push_back({2'b01, 8'hA5});
        send_frame(8'hA5, 1'b0);
        hold_bits(1'b0, 3);
        @(negedge clk);
        check("break_busy", busy, 1);
        check("break_no_valid", valid, 0);
        @(posedge clk); #1;
        hold_bits(1'b1, 2);
        @(negedge clk);
        check("break_exit_idle", busy, 0);
        check("break_single_entry", exp_q.size(), 0);
        @(posedge clk); #1;
        exp_q.push_back({2'b00, 8'h3C}); send_frame(8'h3C, 1'b1);
        hold_bits(1'b1, 2);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back({2'b10, 8'h07}); send_with_parity(8'h07, 1'b0);
        exp_q.push_back({2'b00, 8'h07}); send_with_parity(8'h07, 1'b1);
        hold_bits(1'b1, 2);
`endif

        // Five frames into a four-entry FIFO with the consumer stalled.
        check("no_early_overflow", ovf_cnt, 0);
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ab = 8'(i);
            if (i <= 4) exp_q.push_back({2'b00, ab});
            send_frame(ab, 1'b1);
        end
        hold_bits(1'b1, 2);
        check("overflow_pulses", ovf_cnt, 1);
        @(negedge clk);
        check("full_valid", valid, 1);
        check("full_head", data, 8'h01);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("head_stable", data, 8'h01);
        @(posedge clk); #1;
        ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_done", exp_q.size(), 0);
        check("drain_valid_low", valid, 0);
        @(posedge clk); #1;

        // Reset in DATA bit 4 with two entries queued.
        ready = 1'b0;
        exp_q.push_back({2'b00, 8'h66}); send_frame(8'h66, 1'b1);
        exp_q.push_back({2'b00, 8'h77}); send_frame(8'h77, 1'b1);
        hold_bits(1'b1, 1);
        @(negedge clk);
        check("queued_valid", valid, 1);
        @(posedge clk); #1;
        ab = 8'hC3;
        hold_bits(1'b0, 1);
        for (int i = 0; i < 4; i++) hold_bits(ab[i], 1);
        rxd = ab[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        ready = 1'b1;
        hold_bits(1'b1, 2);
        exp_q.push_back({2'b00, 8'h5A}); send_frame(8'h5A, 1'b1);
        hold_bits(1'b1, 2);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
